// File: rtl/srlatch_pkg.sv
// Shared definitions for the 4-bit gated SR latch bank controller.
//   state_e       : sequencer states, also visible on the controller's debug port
//   req_id_t      : identifies one of the two requesters
//   W_DEF         : default latch bank width
//   PULSE_CYC_DEF : default number of cycles En stays high per write
//   CNT_W         : width of the En pulse down-counter (covers PULSE_CYC 1..15)
package srlatch_pkg;

  localparam int W_DEF         = 4;
  localparam int PULSE_CYC_DEF = 2;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK
  } state_e;

  typedef logic req_id_t;

  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/srlatch_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock and synchronous active-low reset (pointer returns to requester 0)
//   req_i      : request per requester
//   adv_i      : grant is being taken this cycle; move the pointer past the winner
//   gnt_o      : one-hot grant (all zero when no request is pending)
// The pointer names the preferred requester; it is served when requesting,
// otherwise the other requester wins.
module srlatch_rr_arb2
  import srlatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  req_id_t ptr_q;
  req_id_t ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ptr_q]) begin
      gnt_o = id_to_onehot(ptr_q);
    end else if (req_i[~ptr_q]) begin
      gnt_o = id_to_onehot(~ptr_q);
    end
  end

  // After a grant the pointer prefers the requester that lost (or was idle).
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (gnt_o != 2'b00)) begin
      ptr_d = ~gnt_o[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/srlatch4_ctrl.sv
// Sequencer and 2-requester arbiter driving a gated SR latch bank.
//   clk, rst_n        : clock, synchronous active-low reset
//   req               : level request per requester, held until its ack
//   set0/clr0         : requester 0 set / clear masks (sampled at grant)
//   set1/clr1         : requester 1 set / clear masks (sampled at grant)
//   ack               : one-cycle completion pulse per requester
//   err_overlap       : pulses with ack when the granted set&clr overlapped
//   S, R, En          : latch bank controls
//   Q                 : latch bank output feedback
//   shadow            : expected latch contents
//   busy              : high whenever the sequencer is not idle
//   mismatch          : sticky, Q differed from shadow in a check cycle
//   state_dbg         : current sequencer state
// Handshake: a requester raises req[i] with stable masks and keeps it high;
// the masks are captured on the grant cycle and ack[i] pulses for exactly one
// cycle when the write has been applied and checked. A req still high in the
// ack cycle is treated as a fresh request in the following idle cycle.
// Write sequence: SETUP (S/R driven, En=0) -> PULSE (En=1 for PULSE_CYC
// cycles) -> HOLD (En=0, S/R still held) -> CHECK (S/R released, Q checked).
// After reset the same sequence clears the whole bank without an ack.
module srlatch4_ctrl
  import srlatch_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] set0,
  input  logic [W-1:0] clr0,
  input  logic [W-1:0] set1,
  input  logic [W-1:0] clr1,
  output logic [1:0]   ack,
  output logic         err_overlap,
  output logic [W-1:0] S,
  output logic [W-1:0] R,
  output logic         En,
  input  logic [W-1:0] Q,
  output logic [W-1:0] shadow,
  output logic         busy,
  output logic         mismatch,
  output state_e       state_dbg
);

  state_e             state_q;
  state_e             state_d;
  logic [W-1:0]       eff_set_q;
  logic [W-1:0]       eff_clr_q;
  logic               ovl_q;
  req_id_t            gid_q;
  logic               init_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       shadow_q;
  logic               mismatch_q;

  logic [1:0]         gnt;
  logic               arb_adv;
  logic [W-1:0]       sel_set;
  logic [W-1:0]       sel_clr;
  logic [W-1:0]       new_set;
  logic [W-1:0]       new_clr;

  assign arb_adv = (state_q == ST_IDLE) && (req != 2'b00);

  srlatch_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .adv_i (arb_adv),
    .gnt_o (gnt)
  );

  assign sel_set = gnt[1] ? set1 : set0;
  assign sel_clr = gnt[1] ? clr1 : clr0;
  // Bits asked to be both set and cleared are dropped, so S&R is always 0.
  assign new_set = sel_set & ~sel_clr;
  assign new_clr = sel_clr & ~sel_set;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_SETUP;
      ST_IDLE: begin
        if (arb_adv) begin
          state_d = ((new_set | new_clr) != '0) ? ST_SETUP : ST_CHECK;
        end
      end
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD:  state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  // Datapath registers: captured masks, pulse counter, shadow and mismatch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eff_set_q  <= '0;
      eff_clr_q  <= '0;
      ovl_q      <= 1'b0;
      gid_q      <= 1'b0;
      init_q     <= 1'b0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          eff_set_q <= '0;
          eff_clr_q <= '1;
          ovl_q     <= 1'b0;
          init_q    <= 1'b1;
        end
        ST_IDLE: begin
          if (arb_adv) begin
            eff_set_q <= new_set;
            eff_clr_q <= new_clr;
            ovl_q     <= ((sel_set & sel_clr) != '0);
            gid_q     <= gnt[1];
            init_q    <= 1'b0;
          end
        end
        ST_SETUP: cnt_q <= CNT_W'(PULSE_CYC - 1);
        ST_PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD:  shadow_q <= (shadow_q | eff_set_q) & ~eff_clr_q;
        ST_CHECK: begin
          if (Q != shadow_q) begin
            mismatch_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    S           = '0;
    R           = '0;
    En          = 1'b0;
    ack         = 2'b00;
    err_overlap = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_SETUP, ST_HOLD: begin
        S = eff_set_q;
        R = eff_clr_q;
      end
      ST_PULSE: begin
        S  = eff_set_q;
        R  = eff_clr_q;
        En = 1'b1;
      end
      ST_CHECK: begin
        if (!init_q) begin
          ack         = id_to_onehot(gid_q);
          err_overlap = ovl_q;
        end
      end
      default: ;
    endcase
  end

  assign shadow    = shadow_q;
  assign mismatch  = mismatch_q;
  assign state_dbg = state_q;

endmodule
